// File: rtl/ising_sweep_ctrl.sv
// Checkerboard sweep sequencer for an LxL Ising lattice held in registers; feeds one spin-update cell.
// Define ISING_MAG_EN to add mag_o, an incrementally maintained count of up spins.
module ising_sweep_ctrl #(
  parameter int L        = 8,
  parameter int CELL_LAT = 1,
  parameter int SW_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [SW_W-1:0]        num_sweeps_i,
  input  logic                   ld_we_i,
  input  logic [2*$clog2(L)-1:0] ld_addr_i,
  input  logic                   ld_val_i,
  output logic                   rd_val_o,
  output logic                   spin_val_o,
  output logic                   left_o,
  output logic                   right_o,
  output logic                   top_o,
  output logic                   bottom_o,
  output logic                   cell_en_o,
  input  logic                   cell_result_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [SW_W-1:0]        sweep_cnt_o
`ifdef ISING_MAG_EN
  ,
  output logic [2*$clog2(L):0]   mag_o
`endif
);
  localparam int LW  = $clog2(L);
  localparam int AW  = 2 * LW;
  localparam int N   = L * L;
  localparam int WCW = (CELL_LAT > 2) ? $clog2(CELL_LAT) : 1;
  // The last visited site is N-1 in phase 0 and N-2 in phase 1, so either ends the phase.
  localparam logic [AW-1:0]  PHASE_END = AW'(N - 2);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'((CELL_LAT >= 2) ? CELL_LAT - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   site_q, site_d;
  logic            phase_q, phase_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [SW_W-1:0] sweep_q, sweep_d;
  logic [SW_W-1:0] num_q, num_d;
  logic [N-1:0]    lat_q;
  logic            rd_q;
  logic            spin_q, left_q, right_q, top_q, bottom_q;

  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic            lat_wdata;
  logic            cap_nb;

  logic [LW-1:0]   x, y, xm, xp, ym, yp;
  logic [SW_W-1:0] sweep_inc;

  assign x         = site_q[LW-1:0];
  assign y         = site_q[AW-1:LW];
  assign xm        = x - LW'(1);
  assign xp        = x + LW'(1);
  assign ym        = y - LW'(1);
  assign yp        = y + LW'(1);
  assign sweep_inc = sweep_q + SW_W'(1);

  always_comb begin
    state_d   = state_q;
    site_d    = site_q;
    phase_d   = phase_q;
    wait_d    = wait_q;
    sweep_d   = sweep_q;
    num_d     = num_q;
    lat_we    = 1'b0;
    lat_addr  = site_q;
    lat_wdata = cell_result_i;
    cap_nb    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A load in the same cycle as start commits before the run reads the lattice.
        if (ld_we_i) begin
          lat_we    = 1'b1;
          lat_addr  = ld_addr_i;
          lat_wdata = ld_val_i;
        end
        if (start_i) begin
          sweep_d = '0;
          num_d   = num_sweeps_i;
          phase_d = 1'b0;
          site_d  = '0;
          state_d = (num_sweeps_i == '0) ? S_DONE : S_SEEK;
        end
      end
      S_SEEK: begin
        if ((site_q[0] ^ site_q[LW]) == phase_q) begin
          cap_nb  = 1'b1;
          wait_d  = '0;
          state_d = S_ISSUE;
        end else begin
          site_d = site_q + AW'(1);
        end
      end
      S_ISSUE: state_d = (CELL_LAT > 1) ? S_WAIT : S_WRITE;
      S_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = S_WRITE;
        else                     wait_d  = wait_q + WCW'(1);
      end
      S_WRITE: begin
        lat_we  = 1'b1;
        state_d = S_SEEK;
        if (site_q >= PHASE_END) begin
          site_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            sweep_d = sweep_inc;
            phase_d = 1'b0;
            if (sweep_inc == num_q) state_d = S_DONE;
          end
        end else begin
          site_d = site_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      site_q   <= '0;
      phase_q  <= 1'b0;
      wait_q   <= '0;
      sweep_q  <= '0;
      num_q    <= '0;
      lat_q    <= '0;
      rd_q     <= 1'b0;
      spin_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      top_q    <= 1'b0;
      bottom_q <= 1'b0;
    end else begin
      state_q <= state_d;
      site_q  <= site_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
      sweep_q <= sweep_d;
      num_q   <= num_d;
      rd_q    <= lat_q[ld_addr_i];
      if (lat_we) lat_q[lat_addr] <= lat_wdata;
      // Neighbours are snapshotted once per visit and stay frozen until the next visit.
      if (cap_nb) begin
        spin_q   <= lat_q[site_q];
        left_q   <= lat_q[{y, xm}];
        right_q  <= lat_q[{y, xp}];
        top_q    <= lat_q[{ym, x}];
        bottom_q <= lat_q[{yp, x}];
      end
    end
  end

`ifdef ISING_MAG_EN
  logic [AW:0] mag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mag_q <= '0;
    end else if (lat_we && (lat_q[lat_addr] != lat_wdata)) begin
      mag_q <= lat_wdata ? (mag_q + (AW+1)'(1)) : (mag_q - (AW+1)'(1));
    end
  end

  assign mag_o = mag_q;
`endif

  assign rd_val_o    = rd_q;
  assign spin_val_o  = spin_q;
  assign left_o      = left_q;
  assign right_o     = right_q;
  assign top_o       = top_q;
  assign bottom_o    = bottom_q;
  assign cell_en_o   = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign sweep_cnt_o = sweep_q;

endmodule

// File: tb/tb_ising_sweep_ctrl.sv
// Self-checking bench for ising_sweep_ctrl: table of runs checked against a lattice-level model.
// Build with ISING_MAG_EN defined to also check the up-spin count.
module tb_ising_sweep_ctrl;
  localparam int CL = 3;
  localparam int NS = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_sweeps = '0;
  logic        ld_we = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic        ld_val = 1'b0;
  logic        rd_val, spin_val, left, right, top, bottom, cell_en, cell_result;
  logic        busy, done;
  logic [15:0] sweep_cnt;
`ifdef ISING_MAG_EN
  logic [6:0]  mag;
`endif

  int mode = 0;  // 0: invert, 1: echo, 2: spin ^ neighbour parity
  assign cell_result = (mode == 0) ? ~spin_val :
                       (mode == 1) ? spin_val :
                       (spin_val ^ left ^ right ^ top ^ bottom);

  ising_sweep_ctrl #(.L(8), .CELL_LAT(CL), .SW_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_sweeps_i(num_sweeps),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_val_i(ld_val), .rd_val_o(rd_val),
    .spin_val_o(spin_val), .left_o(left), .right_o(right), .top_o(top), .bottom_o(bottom),
    .cell_en_o(cell_en), .cell_result_i(cell_result), .busy_o(busy), .done_o(done),
    .sweep_cnt_o(sweep_cnt)
`ifdef ISING_MAG_EN
    , .mag_o(mag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int nsw; int mode; int pat; bit inject; bit same_ld; int exp_cnt; int exp_ones;
  } vec_t;

  int checks = 0;
  int errors = 0;
  bit [NS-1:0] mdl;
  bit rec_l [NS];
  bit rec_r [NS];
  bit rec_t [NS];
  bit rec_b [NS];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int nb(int s, int dx, int dy);
    int x = s % 8;
    int y = s / 8;
    return ((y + dy + 8) % 8) * 8 + ((x + dx + 8) % 8);
  endfunction

  function automatic bit rule(int m, bit s, bit l, bit r, bit t, bit b);
    if (m == 0) return ~s;
    if (m == 1) return s;
    return s ^ l ^ r ^ t ^ b;
  endfunction

  task automatic load(bit [NS-1:0] p);
    for (int a = 0; a < NS; a++) begin
      ld_we = 1'b1; ld_addr = 6'(a); ld_val = p[a];
      @(negedge clk);
    end
    ld_we = 1'b0;
    mdl = p;
  endtask

  task automatic readback(output bit [NS-1:0] v);
    for (int a = 0; a < NS; a++) begin
      ld_addr = 6'(a);
      @(negedge clk);
      v[a] = rd_val;
    end
  endtask

  task automatic run_vec(int idx, int nsw, bit inject, bit same_ld, int abort_at);
    int vq[$];
    int cyc = 0, busy_cnt = 0, en_cnt = 0, visits = 0, budget;
    bit prev_en = 1'b0, seen_done = 1'b0, any_done;
    bit [4:0] exp_v, act_v;
    start = 1'b1; num_sweeps = 16'(nsw);
    if (same_ld) begin
      ld_we = 1'b1; ld_addr = 6'd9; ld_val = ~mdl[9];
      mdl[9] = ~mdl[9];
    end
    for (int s = 0; s < nsw; s++)
      for (int ph = 0; ph < 2; ph++)
        for (int site = 0; site < NS; site++)
          if ((((site % 8) + (site / 8)) % 2) == ph) vq.push_back(site);
    @(negedge clk);
    start = 1'b0; ld_we = 1'b0;
    budget = (nsw + 1) * 500;
    while (!seen_done && cyc < budget) begin
      if (busy) busy_cnt++;
      if (cell_en) en_cnt++;
      if (done) seen_done = 1'b1;
      if (cell_en && !prev_en) begin
        visits++;
        if (vq.size() == 0) begin
          chk($sformatf("vec%0d_extra_visit", idx), 64'(visits), 64'(nsw * NS));
        end else begin
          int s = vq.pop_front();
          exp_v = {mdl[s], mdl[nb(s, -1, 0)], mdl[nb(s, 1, 0)], mdl[nb(s, 0, -1)], mdl[nb(s, 0, 1)]};
          act_v = {spin_val, left, right, top, bottom};
          chk($sformatf("vec%0d_visit_site%0d_spin_l_r_t_b", idx, s), 64'(act_v), 64'(exp_v));
          rec_l[s] = left; rec_r[s] = right; rec_t[s] = top; rec_b[s] = bottom;
          mdl[s] = rule(mode, exp_v[4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
        end
        if (abort_at > 0 && visits == abort_at) begin
          rst = 1'b1;
          @(negedge clk);
          chk("abort_busy_cell_en", {62'd0, busy, cell_en}, 64'd0);
          rst = 1'b0;
          mdl = '0;
          any_done = 1'b0;
          for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) any_done = 1'b1;
          end
          chk("abort_no_done_no_busy", 64'(any_done), 64'd0);
          $display("vec %0d aborted after %0d visits", idx, visits);
          return;
        end
      end
      prev_en = cell_en;
      if (inject && cyc == 100) begin
        start = 1'b1; num_sweeps = 16'd7;
        ld_we = 1'b1; ld_addr = 6'd5; ld_val = ~mdl[5];
      end
      if (inject && cyc == 101) begin
        start = 1'b0; ld_we = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    chk($sformatf("vec%0d_done_seen", idx), 64'(seen_done), 64'd1);
    chk($sformatf("vec%0d_busy_cycles", idx), 64'(busy_cnt), 64'(nsw * (64 * (CL + 1) + 127) + 1));
    chk($sformatf("vec%0d_cell_en_cycles", idx), 64'(en_cnt), 64'(nsw * NS * CL));
    chk($sformatf("vec%0d_missed_visits", idx), 64'(vq.size()), 64'd0);
    chk($sformatf("vec%0d_after_done_busy_done", idx), {62'd0, busy, done}, 64'd0);
    $display("vec %0d nsw=%0d mode=%0d busy_cycles=%0d visits=%0d", idx, nsw, mode, busy_cnt, visits);
  endtask

  initial begin
    vec_t vecs [8];
    bit [NS-1:0] pat, rb;
    bit [4:0] nbv;
    vecs[0] = '{1, 0, 0, 1'b0, 1'b0, 1, 0};
    vecs[1] = '{2, 0, 0, 1'b0, 1'b0, 2, 64};
    vecs[2] = '{0, 0, 0, 1'b0, 1'b0, 0, 64};
    vecs[3] = '{1, 1, 2, 1'b0, 1'b0, 1, 3};
    vecs[4] = '{2, 2, 1, 1'b1, 1'b0, 2, -1};
    vecs[5] = '{3, 2, 1, 1'b0, 1'b1, 3, -1};
    vecs[6] = '{1, 0, 4, 1'b0, 1'b0, 1, 54};
    vecs[7] = '{1, 2, 1, 1'b1, 1'b1, 1, -1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {busy, done, cell_en, spin_val, left, right, top, bottom, rd_val, sweep_cnt},
        64'd0);
    readback(rb);
    chk("reset_lattice", rb, 64'd0);
`ifdef ISING_MAG_EN
    chk("reset_mag", 64'(mag), 64'd0);
`endif

    for (int v = 0; v < 8; v++) begin
      case (vecs[v].pat)
        0:       pat = '1;
        2:       pat = 64'h0100_0000_0000_0081;
        4:       pat = 64'h0000_0000_0000_03FF;
        default: pat = {$urandom, $urandom};
      endcase
      mode = vecs[v].mode;
      load(pat);
      readback(rb);
      chk($sformatf("vec%0d_load_readback", v), rb, mdl);
`ifdef ISING_MAG_EN
      chk($sformatf("vec%0d_mag_after_load", v), 64'(mag), 64'($countones(mdl)));
`endif
      run_vec(v, vecs[v].nsw, vecs[v].inject, vecs[v].same_ld, 0);
      chk($sformatf("vec%0d_sweep_cnt", v), 64'(sweep_cnt), 64'(vecs[v].exp_cnt));
      readback(rb);
      chk($sformatf("vec%0d_final_lattice", v), rb, mdl);
      if (vecs[v].exp_ones >= 0)
        chk($sformatf("vec%0d_up_count", v), 64'($countones(rb)), 64'(vecs[v].exp_ones));
`ifdef ISING_MAG_EN
      chk($sformatf("vec%0d_mag_after_run", v), 64'(mag), 64'($countones(mdl)));
`endif
      if (v == 3) begin
        nbv = {rec_l[0], rec_t[0], rec_r[63], rec_b[63], rec_r[0]};
        chk("wrap_neighbours_site0_site63", 64'(nbv), 64'b11110);
      end
    end

    mode = 2;
    load({$urandom, $urandom});
    run_vec(8, 1, 1'b0, 1'b0, 40);
    readback(rb);
    chk("abort_lattice_cleared", rb, 64'd0);
    chk("abort_sweep_cnt", 64'(sweep_cnt), 64'd0);
`ifdef ISING_MAG_EN
    chk("abort_mag", 64'(mag), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
